// File: rtl/memarb.sv
// Two-port arbiter/sequencer for the shared 64 x 8 external memory.
// Serialises r0/r1 request/ack transactions onto registered memory strobes.
module memarb #(
  parameter int AW         = 6,
  parameter int DW         = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;
  logic   start_s;
  logic   grant_s;
  logic   win_r;
  logic   last_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and winner selection; inputs only matter while IDLE
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (r0_req || r1_req) begin
          start_s = 1'b1;
          state_s = ACCESS;
          if (r0_req && r1_req) begin
            // last_r = 1 means r1 was granted last, so r0 takes the tie
            grant_s = FIXED_PRIO ? 1'b0 : ~last_r;
          end else begin
            grant_s = r1_req;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory strobes, acks, read-data capture and arbitration history
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      win_r     <= 1'b0;
      last_r    <= 1'b1;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            mem_addr  <= grant_s ? r1_addr : r0_addr;
            mem_din   <= grant_s ? r1_wdata : r0_wdata;
            mem_write <= grant_s ? r1_we : r0_we;
            mem_read  <= grant_s ? ~r1_we : ~r0_we;
            win_r     <= grant_s;
            last_r    <= grant_s;
          end
        end
        ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (win_r) begin
            r1_ack <= 1'b1;
            if (mem_read) begin
              r1_rdata <= mem_dout;
            end
          end else begin
            r0_ack <= 1'b1;
            if (mem_read) begin
              r0_rdata <= mem_dout;
            end
          end
        end
        DONE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
